// File: rtl/fpu_share_arb.sv
// rtl/fpu_share_arb.sv - round-robin sharing of one fixed-latency FPU unit with tag-routed results
module fpu_share_arb #(
  parameter int NREQ    = 4,
  parameter int LATENCY = 1,
  parameter int W       = 32
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  input  logic              hold,
  output logic [W-1:0]      unit_a_data,
  output logic              unit_a_valid,
  input  logic [W-1:0]      unit_c_data,
  input  logic              unit_c_valid,
  output logic [NREQ-1:0]   resp_valid,
  output logic [W-1:0]      resp_data,
  output logic              busy,
  output logic              err
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(LATENCY + 3) + 1;

  logic [IW-1:0] ptr;
  logic [IW-1:0] grant_id;
  logic [IW-1:0] issue_id;
  logic          accept;

  logic [LATENCY-1:0] tag_v;
  logic [IW-1:0]      tag_id [LATENCY];
  logic               tail_v;
  logic [IW-1:0]      tail_id;
  logic               lost;

  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;

  assign tail_v  = tag_v[LATENCY-1];
  assign tail_id = tag_id[LATENCY-1];
  assign lost    = tail_v & ~unit_c_valid;
  assign busy    = (count != '0);

  // Round-robin scan from ptr; the lowest offset with a valid request wins.
  // Gated by aresetn so req_ready reads zero while reset is held.
  always_comb begin
    int idx;
    idx       = 0;
    grant_id  = '0;
    accept    = 1'b0;
    req_ready = '0;
    if (aresetn && !hold) begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        idx = (int'(ptr) + k) % NREQ;
        if (req_valid[idx]) begin
          grant_id = IW'(idx);
          accept   = 1'b1;
        end
      end
    end
    if (accept) req_ready[grant_id] = 1'b1;
  end

  // Pointer advance past the granted requester and the registered issue stage.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ptr          <= '0;
      unit_a_valid <= 1'b0;
      unit_a_data  <= '0;
      issue_id     <= '0;
    end else begin
      unit_a_valid <= accept;
      if (accept) begin
        ptr         <= (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + IW'(1);
        unit_a_data <= req_data[int'(grant_id)*W +: W];
        issue_id    <= grant_id;
      end
    end
  end

  // Tag pipeline mirrors the unit latency so the tail lines up with unit_c_valid.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tag_v <= '0;
      for (int i = 0; i < LATENCY; i++) tag_id[i] <= '0;
    end else begin
      tag_v[0]  <= unit_a_valid;
      tag_id[0] <= issue_id;
      for (int i = 1; i < LATENCY; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  // Route the result to its issuer; any disagreement between unit and tags is sticky.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      resp_valid <= '0;
      resp_data  <= '0;
      err        <= 1'b0;
    end else begin
      resp_valid <= '0;
      if (unit_c_valid && tail_v) resp_valid[tail_id] <= 1'b1;
      if (unit_c_valid) resp_data <= unit_c_data;
      if (unit_c_valid != tail_v) err <= 1'b1;
    end
  end

  // Outstanding count: accepts in, responses and lost results out, clamped to its legal range.
  always_comb begin
    int c;
    c = int'(count) + int'(accept) - int'(|resp_valid) - int'(lost);
    if (c < 0) c = 0;
    if (c > LATENCY + 2) c = LATENCY + 2;
    count_nxt = CW'(c);
  end

  // Outstanding count register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) count <= '0;
    else          count <= count_nxt;
  end

endmodule

// File: tb/tb_fpu_share_arb.sv
// tb/tb_fpu_share_arb.sv - directed bench for fpu_share_arb with a negate unit model
module tb_fpu_share_arb;

  localparam int NREQ = 4;
  localparam int W    = 32;

  logic            aclk;
  logic            aresetn;
  logic [NREQ-1:0] req_valid;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0] req_ready;
  logic            hold;
  logic [W-1:0]    unit_a_data;
  logic            unit_a_valid;
  logic [W-1:0]    unit_c_data;
  logic            unit_c_valid;
  logic [NREQ-1:0] resp_valid;
  logic [W-1:0]    resp_data;
  logic            busy;
  logic            err;

  logic         m_cv;
  logic [W-1:0] m_cd;
  logic         force_cv;

  int n_tests = 0;
  int n_fail  = 0;

  fpu_share_arb #(.NREQ(NREQ), .LATENCY(1), .W(W)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .hold(hold),
    .unit_a_data(unit_a_data), .unit_a_valid(unit_a_valid),
    .unit_c_data(unit_c_data), .unit_c_valid(unit_c_valid),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .busy(busy), .err(err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Negate unit, latency 1, shares the reset.
  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_cv <= 1'b0;
      m_cd <= '0;
    end else begin
      m_cv <= unit_a_valid;
      m_cd <= unit_a_data ^ 32'h8000_0000;
    end
  end
  assign unit_c_valid = m_cv | force_cv;
  assign unit_c_data  = m_cd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    int          due;
    logic [3:0]  oh;
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  int          mcyc = 0;
  int          mptr = 0;
  logic        prev_acc = 1'b0;
  logic [31:0] prev_data = '0;

  // Per-cycle scoreboard: arbitration model, issue stage, response order/latency, busy.
  always @(negedge aclk) begin
    logic [3:0] eg;
    int gid;
    eg  = '0;
    gid = 0;
    if (!aresetn) begin
      q.delete();
      mptr     = 0;
      prev_acc = 1'b0;
      chk("rst_resp_valid", 32'(resp_valid), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
    end else begin
      mcyc++;
      chk("mon_busy", 32'(busy), 32'(q.size() != 0));
      if (q.size() > 0 && q[0].due == mcyc) begin
        chk("mon_resp_valid", 32'(resp_valid), 32'(q[0].oh));
        chk("mon_resp_data", resp_data, q[0].data);
        void'(q.pop_front());
      end else begin
        chk("mon_resp_idle", 32'(resp_valid), 32'h0);
      end
      chk("mon_a_valid", 32'(unit_a_valid), 32'(prev_acc));
      if (prev_acc) chk("mon_a_data", unit_a_data, prev_data);
      if (!hold) begin
        for (int k = NREQ - 1; k >= 0; k--) begin
          int idx;
          idx = (mptr + k) % NREQ;
          if (req_valid[idx]) begin
            eg  = 4'(1 << idx);
            gid = idx;
          end
        end
      end
      chk("mon_req_ready", 32'(req_ready), 32'(eg));
      prev_acc = (eg != 0);
      if (prev_acc) begin
        exp_t e;
        prev_data = req_data[gid*W +: W];
        e.due  = mcyc + 3;
        e.oh   = eg;
        e.data = prev_data ^ 32'h8000_0000;
        q.push_back(e);
        mptr = (gid + 1) % NREQ;
      end
    end
  end

  typedef struct {
    logic [3:0] rv;
    logic       hold;
    logic [3:0] exp_ready;
  } vec_t;

  vec_t vecs[14];

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_data(input int tag);
    for (int i = 0; i < NREQ; i++) req_data[i*W +: W] = 32'h4000_0000 | (tag << 8) | i;
  endtask

  initial begin
    // Arbitration table; pointer is 3 entering it (after T1 grants requester 2).
    vecs[0]  = '{4'b0011, 1'b0, 4'b0001};
    vecs[1]  = '{4'b0011, 1'b0, 4'b0010};
    vecs[2]  = '{4'b0011, 1'b0, 4'b0001};  // ptr=2: scan 2,3,0
    vecs[3]  = '{4'b0011, 1'b0, 4'b0010};
    vecs[4]  = '{4'b1111, 1'b1, 4'b0000};
    vecs[5]  = '{4'b0000, 1'b0, 4'b0000};
    vecs[6]  = '{4'b1000, 1'b0, 4'b1000};
    vecs[7]  = '{4'b1111, 1'b0, 4'b0001};
    vecs[8]  = '{4'b1010, 1'b0, 4'b0010};
    vecs[9]  = '{4'b1010, 1'b0, 4'b1000};
    vecs[10] = '{4'b0110, 1'b0, 4'b0010};
    vecs[11] = '{4'b0100, 1'b0, 4'b0100};
    vecs[12] = '{4'b1000, 1'b0, 4'b1000};
    vecs[13] = '{4'b0000, 1'b0, 4'b0000};

    aresetn   = 1'b0;
    req_valid = 4'b1111;
    req_data  = '0;
    hold      = 1'b0;
    force_cv  = 1'b0;
    step();
    step();
    chk("reset_req_ready", 32'(req_ready), 32'h0);
    chk("reset_a_valid", 32'(unit_a_valid), 32'h0);
    chk("reset_a_data", unit_a_data, 32'h0);
    chk("reset_resp_data", resp_data, 32'h0);
    chk("reset_err", 32'(err), 32'h0);
    req_valid = '0;
    aresetn   = 1'b1;
    step();

    // T1: single op from requester 2
    req_valid = 4'b0100;
    req_data[2*W +: W] = 32'h3F80_0000;
    #1 chk("t1_ready", 32'(req_ready), 32'h4);
    step();
    req_valid = '0;
    chk("t1_a_valid", 32'(unit_a_valid), 32'h1);
    chk("t1_a_data", unit_a_data, 32'h3F80_0000);
    step();
    step();
    chk("t1_resp_valid", 32'(resp_valid), 32'h4);
    chk("t1_resp_data", resp_data, 32'hBF80_0000);
    step();

    // Table-driven arbitration vectors (includes T3 and a hold cycle)
    for (int v = 0; v < 14; v++) begin
      req_valid = vecs[v].rv;
      hold      = vecs[v].hold;
      set_data(v);
      #1 chk($sformatf("vec%0d_ready", v), 32'(req_ready), 32'(vecs[v].exp_ready));
      step();
    end
    req_valid = '0;
    hold      = 1'b0;
    repeat (4) step();
    chk("drain_busy", 32'(busy), 32'h0);

    // T2: all requesting from ptr=0 -> 0,1,2,3,0,...
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      set_data(32 + k);
      #1 chk($sformatf("t2_ready%0d", k), 32'(req_ready), 32'(1 << (k % 4)));
      step();
    end

    // T4: hold with everyone requesting; in-flight drains
    hold = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1 chk($sformatf("t4_ready%0d", k), 32'(req_ready), 32'h0);
      step();
    end
    chk("t4_busy", 32'(busy), 32'h0);
    chk("t4_err", 32'(err), 32'h0);
    hold      = 1'b0;
    req_valid = '0;
    step();

    // T5: spurious unit result with an empty pipeline
    force_cv = 1'b1;
    step();
    force_cv = 1'b0;
    chk("t5_err", 32'(err), 32'h1);
    chk("t5_no_resp", 32'(resp_valid), 32'h0);
    repeat (3) step();
    chk("t5_err_sticky", 32'(err), 32'h1);

    // T6: reset between accept and response
    req_valid = 4'b0001;
    set_data(99);
    step();
    req_valid = '0;
    chk("t6_a_valid_pre", 32'(unit_a_valid), 32'h1);
    #1 aresetn = 1'b0;
    #1;
    chk("t6_a_valid", 32'(unit_a_valid), 32'h0);
    chk("t6_resp_valid", 32'(resp_valid), 32'h0);
    chk("t6_busy", 32'(busy), 32'h0);
    chk("t6_err", 32'(err), 32'h0);
    step();
    aresetn = 1'b1;
    repeat (5) step();
    chk("t6_busy_after", 32'(busy), 32'h0);
    chk("t6_err_after", 32'(err), 32'h0);
    chk("t6_queue_empty", 32'(q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
